tdc_sample_ctrl: RTL
====================

// Module: tdc_sample_ctrl
//
// PURPOSE
//  Measurement sequencer for the TDC. It launches the delay line, waits for the line to
//  settle, then strobes the population-count stage's enable and captures the thermometer
//  count. It repeats this for a programmable number of samples. Sum, min and max of the
//  counts are returned on a valid/ready result port for averaging.
//  Sits between the host/register interface and the delay-line + pop_count datapath.
//
// PARAMETERS
//  N         64  thermometer width of the delay line; count width is $clog2(N)+1
//  SAMPLES_W 4   width of n_samples; up to 2**SAMPLES_W samples per measurement
//  SETTLE    2   idle cycles between launch and pc_en (>=0)
//  LAT       1   cycles from pc_en high to pc_y valid (>=1; pop_count registers on en)
//
// PORTS
//  clk        in   1                    single clock, rising edge
//  rst_n      in   1                    asynchronous, active-low reset
//  start      in   1                    request a measurement; sampled only in IDLE
//  abort      in   1                    synchronous abort; return to IDLE, no result
//  n_samples  in   SAMPLES_W            samples to take minus one; latched on start
//  busy       out  1                    high in every state except IDLE
//  launch     out  1                    one-cycle pulse firing the delay line
//  pc_en      out  1                    one-cycle enable to the popcount output register
//  pc_y       in   $clog2(N)+1          popcount result, 0..N
//  res_valid  out  1                    result available; held until res_ready
//  res_ready  in   1                    consumer accepts result
//  res_sum    out  $clog2(N)+SAMPLES_W+1 sum of all sample counts; cannot overflow
//  res_min    out  $clog2(N)+1          smallest sample count
//  res_max    out  $clog2(N)+1          largest sample count
//
// BEHAVIOUR
//  - Reset (rst_n low, any time, including mid-measurement):
//    state=IDLE; all outputs 0 except res_min=N; internal counters 0.
//  - States:
//    IDLE -> LAUNCH -> SETTLE(SETTLE cyc) -> SAMPLE -> WAIT(LAT-1 cyc) -> ACC -> LAUNCH | DONE.
//    SETTLE is skipped when SETTLE=0. WAIT is skipped when LAT=1.
//  - IDLE:
//    - When start=1: latch rem=n_samples, clear res_sum, set res_min=N and res_max=0,
//      go to LAUNCH.
//  - LAUNCH: launch=1 for exactly one cycle.
//  - SAMPLE: pc_en=1 for exactly one cycle.
//  - ACC:
//    - pc_y is valid in this cycle.
//    - res_sum += pc_y (zero-extended).
//    - res_min/res_max are updated with unsigned compares.
//    - If rem==0, go to DONE; else rem-=1 and go to LAUNCH.
//  - Sample period is SETTLE+LAT+2 cycles.
//  - res_valid rises (n_samples+1)*(SETTLE+LAT+2)+1 cycles after the cycle in which start
//    was sampled.
//  - DONE:
//    - res_valid=1.
//    - res_sum, res_min and res_max are stable and do not change while res_valid=1.
//    - On res_valid&&res_ready: res_valid=0 next cycle, state=IDLE. Results keep their
//      values until the next start.
//    - start is ignored in DONE. A start in the same cycle as the handshake is not
//      accepted; it must be held one more cycle.
//  - start is ignored while busy=1. n_samples changes while busy have no effect.
//  - abort:
//    - In any non-IDLE state, including DONE, the next state is IDLE with res_valid=0,
//      launch=0 and pc_en=0.
//    - abort has priority over the handshake, ACC transitions and start.
//    - Partial results are not presented.
//  - pc_y is only sampled in ACC. Values at other times are don't-care.
//  - launch and pc_en are never high in the same cycle, and are never high in IDLE or DONE.
//
// TESTING
//  1. Defaults, n_samples=0, pc_y=37 in ACC -> one launch at cycle 1, pc_en at cycle 4;
//     res_valid at cycle 6 with sum=37, min=37, max=37.
//  2. n_samples=3, pc_y sequence 10,12,9,15 -> 4 launches spaced 5 cycles apart;
//     sum=46, min=9, max=15; res_valid at cycle 21.
//  3. n_samples=15, pc_y=64 on every sample -> sum=1024 with no wrap; min=max=64.
//     Check the sum width.
//  4. res_ready held low for 10 cycles in DONE, with start pulsed meanwhile -> outputs stay
//     stable, no new launch; ready=1 -> res_valid falls, IDLE.
//  5. abort during the 2nd SETTLE of n_samples=3 -> IDLE next cycle, res_valid never rises,
//     no further launch/pc_en.
//  6. rst_n pulled low mid-WAIT with LAT=3 (async, between edges) -> outputs cleared
//     immediately, res_min=N; a new start after release runs a clean measurement.

Source files
------------

// File: rtl/tdc_sample_ctrl.sv
// TDC measurement sequencer: launches the delay line, strobes the popcount stage and
// accumulates sum/min/max of the thermometer counts over a programmable sample count.
module tdc_sample_ctrl #(
  parameter int N         = 64,
  parameter int SAMPLES_W = 4,
  parameter int SETTLE    = 2,
  parameter int LAT       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [SAMPLES_W-1:0]          n_samples,
  output logic                          busy,
  output logic                          launch,
  output logic                          pc_en,
  input  logic [$clog2(N):0]            pc_y,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(N)+SAMPLES_W:0]  res_sum,
  output logic [$clog2(N):0]            res_min,
  output logic [$clog2(N):0]            res_max
);

  // state    | meaning
  // S_IDLE   | waiting for start; results hold last measurement
  // S_LAUNCH | one-cycle launch pulse to the delay line
  // S_SETTLE | SETTLE idle cycles for the line to settle
  // S_SAMPLE | one-cycle pc_en to the popcount register
  // S_WAIT   | LAT-1 cycles until pc_y is valid
  // S_ACC    | accumulate pc_y; loop or finish
  // S_DONE   | res_valid held until res_ready

  localparam int CW   = $clog2(N) + 1;
  localparam int SW   = $clog2(N) + SAMPLES_W + 1;
  localparam int TMAX = (SETTLE > LAT) ? SETTLE : LAT;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [TW-1:0] SETTLE_LD = TW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [TW-1:0] WAIT_LD   = TW'((LAT > 1) ? LAT - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SETTLE,
    S_SAMPLE,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [TW-1:0]          tmr;
  logic [SAMPLES_W-1:0]   rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    launch    = 1'b0;
    pc_en     = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        launch = 1'b1;
        if (SETTLE == 0) state_nxt = S_SAMPLE;
        else             state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr == '0) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        pc_en = 1'b1;
        if (LAT <= 1) state_nxt = S_ACC;
        else          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (tmr == '0) state_nxt = S_ACC;
      end
      S_ACC: begin
        if (rem == '0) state_nxt = S_DONE;
        else           state_nxt = S_LAUNCH;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // abort wins over every other transition, including the result handshake
    if (abort) state_nxt = S_IDLE;
  end

  // Timer is loaded on the cycle before the wait state and counts down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else begin
      case (state)
        S_LAUNCH:         tmr <= SETTLE_LD;
        S_SAMPLE:         tmr <= WAIT_LD;
        S_SETTLE, S_WAIT: if (tmr != '0) tmr <= tmr - TW'(1);
        default:          tmr <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      res_sum <= '0;
      res_min <= CW'(N);
      res_max <= '0;
    end else if (!abort) begin
      if (state == S_IDLE && start) begin
        rem     <= n_samples;
        res_sum <= '0;
        res_min <= CW'(N);
        res_max <= '0;
      end else if (state == S_ACC) begin
        res_sum <= res_sum + SW'(pc_y);
        if (pc_y < res_min) res_min <= pc_y;
        if (pc_y > res_max) res_max <= pc_y;
        if (rem != '0) rem <= rem - SAMPLES_W'(1);
      end
    end
  end

endmodule
